// File: rtl/aes_mixcolumn_seq.sv
// Byte-serial AES MixColumn engine (forward/inverse) with valid/ready on both sides.
// Define AES_MIXCOLUMN_SEQ_INV_DIRECT_EN to compute inverse directly instead of via the PRE pass.
module aes_mixcolumn_seq (
    input  logic        g_clk,
    input  logic        g_rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] col_in,
    input  logic        dec,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] col_out,
    output logic        busy
);

`ifdef AES_MIXCOLUMN_SEQ_INV_DIRECT_EN
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_PRE, S_CALC, S_DONE} state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] col_q, col_d;
    logic [31:0] res_q, res_d;
    logic        dec_q, dec_d;
    logic [1:0]  idx_q, idx_d;

    logic [1:0]  i1, i2, i3;
    logic [7:0]  b0, b1, b2, b3;
    logic [7:0]  o_byte;
    logic [7:0]  u, v;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a small constant (<= 4'hf) with a chain of xtime doublings.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] c, input logic [1:0] k);
        return c[{k, 3'b000} +: 8];
    endfunction

    always_comb begin
        i1 = idx_q + 2'd1;
        i2 = idx_q + 2'd2;
        i3 = idx_q + 2'd3;
        b0 = get_byte(col_q, idx_q);
        b1 = get_byte(col_q, i1);
        b2 = get_byte(col_q, i2);
        b3 = get_byte(col_q, i3);
`ifdef AES_MIXCOLUMN_SEQ_INV_DIRECT_EN
        if (dec_q)
            o_byte = gmul(b0, 4'he) ^ gmul(b1, 4'hb) ^ gmul(b2, 4'hd) ^ gmul(b3, 4'h9);
        else
            o_byte = gmul(b0, 4'h2) ^ gmul(b1, 4'h3) ^ b2 ^ b3;
`else
        o_byte = gmul(b0, 4'h2) ^ gmul(b1, 4'h3) ^ b2 ^ b3;
`endif
        // PRE folds the inverse matrix into the forward one: b0,b2 ^= 4(b0^b2); b1,b3 ^= 4(b1^b3).
        u = gmul(col_q[7:0] ^ col_q[23:16], 4'h4);
        v = gmul(col_q[15:8] ^ col_q[31:24], 4'h4);
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        res_d     = res_q;
        dec_d     = dec_q;
        idx_d     = idx_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            S_IDLE: begin
                busy     = 1'b0;
                in_ready = ~g_rst;
                if (in_valid) begin
                    col_d = col_in;
                    dec_d = dec;
                    idx_d = 2'd0;
`ifdef AES_MIXCOLUMN_SEQ_INV_DIRECT_EN
                    state_d = S_CALC;
`else
                    state_d = dec ? S_PRE : S_CALC;
`endif
                end
            end
`ifndef AES_MIXCOLUMN_SEQ_INV_DIRECT_EN
            S_PRE: begin
                if (dec_q)
                    col_d = col_q ^ {v, u, v, u};
                state_d = S_CALC;
            end
`endif
            S_CALC: begin
                res_d[{idx_q, 3'b000} +: 8] = o_byte;
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3)
                    state_d = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            state_q <= S_IDLE;
            col_q   <= 32'h0;
            res_q   <= 32'h0;
            dec_q   <= 1'b0;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            res_q   <= res_d;
            dec_q   <= dec_d;
            idx_q   <= idx_d;
        end
    end

    assign col_out = res_q;

endmodule

// File: tb/tb_aes_mixcolumn_seq.sv
// Self-checking bench for aes_mixcolumn_seq: known vectors, handshake corner cases,
// and random columns against a polynomial-arithmetic MixColumn model.
module tb_aes_mixcolumn_seq;

    logic        g_clk;
    logic        g_rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] col_in;
    logic        dec;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] col_out;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef AES_MIXCOLUMN_SEQ_INV_DIRECT_EN
    localparam int INV_LAT = 4;
`else
    localparam int INV_LAT = 5;
`endif
    localparam int FWD_LAT = 4;

    aes_mixcolumn_seq dut (
        .g_clk     (g_clk),
        .g_rst     (g_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .col_in    (col_in),
        .dec       (dec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .col_out   (col_out),
        .busy      (busy)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    typedef struct {
        logic [31:0] col;
        logic        dec;
        logic [31:0] exp;
    } vec_t;

    // Carry-less polynomial product reduced modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int k = 14; k >= 8; k--)
            if (p[k]) p = p ^ (16'h011b << (k - 8));
        return p[7:0];
    endfunction

    function automatic logic [31:0] ref_mix(input logic [31:0] c, input logic d);
        logic [7:0] b  [4];
        logic [7:0] cf [4];
        logic [7:0] o;
        logic [31:0] r;
        for (int i = 0; i < 4; i++) b[i] = c[8*i +: 8];
        if (d) begin
            cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
        end else begin
            cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01;
        end
        r = 32'h0;
        for (int i = 0; i < 4; i++) begin
            o = 8'h00;
            for (int j = 0; j < 4; j++) o = o ^ gf_mul(cf[j], b[(i + j) % 4]);
            r[8*i +: 8] = o;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    // Hand one column to the engine and wait for its result; lat counts edges after accept.
    task automatic applyStimulus(input logic [31:0] c, input logic d, output int lat, output logic [31:0] res);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        if (!in_ready) checkOutput("in_ready_timeout", {31'h0, in_ready}, 32'h1);
        in_valid = 1'b1;
        col_in   = c;
        dec      = d;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        res = col_out;
    endtask

    vec_t        vecs [8];
    int          lat;
    logic [31:0] res;
    logic [31:0] held;
    logic [31:0] rc;
    logic        rd;

    initial begin
        vecs[0] = '{32'h455313db, 1'b0, 32'hbca14d8e};
        vecs[1] = '{32'hbca14d8e, 1'b1, 32'h455313db};
        vecs[2] = '{32'h5c220af2, 1'b0, 32'h9d58dc9f};
        vecs[3] = '{32'h01010101, 1'b0, 32'h01010101};
        vecs[4] = '{32'h01010101, 1'b1, 32'h01010101};
        vecs[5] = '{32'hc6c6c6c6, 1'b0, 32'hc6c6c6c6};
        vecs[6] = '{32'hc6c6c6c6, 1'b1, 32'hc6c6c6c6};
        vecs[7] = '{32'h9d58dc9f, 1'b1, 32'h5c220af2};

        g_rst     = 1'b1;
        in_valid  = 1'b0;
        col_in    = 32'h0;
        dec       = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        checkOutput("rst_in_ready", {31'h0, in_ready}, 32'h0);
        checkOutput("rst_out_valid", {31'h0, out_valid}, 32'h0);
        checkOutput("rst_busy", {31'h0, busy}, 32'h0);
        checkOutput("rst_col_out", col_out, 32'h0);
        g_rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", {31'h0, in_ready}, 32'h1);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].col, vecs[i].dec, lat, res);
            checkOutput($sformatf("vec%0d_col", i), res, vecs[i].exp);
            checkOutput($sformatf("vec%0d_lat", i), 32'(lat), vecs[i].dec ? 32'(INV_LAT) : 32'(FWD_LAT));
        end

        // Backpressure: result must hold while out_ready is low and new input is refused.
        tick();
        out_ready = 1'b0;
        applyStimulus(32'h455313db, 1'b0, lat, res);
        held     = res;
        checkOutput("bp_first", held, 32'hbca14d8e);
        in_valid = 1'b1;
        col_in   = 32'h12345678;
        dec      = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput($sformatf("bp_hold%0d", i), {out_valid, in_ready, busy, col_out[28:0]},
                        {1'b1, 1'b0, 1'b1, held[28:0]});
            checkOutput($sformatf("bp_col%0d", i), col_out, held);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        checkOutput("bp_release_idle", {29'h0, out_valid, in_ready, busy}, 32'h2);
        checkOutput("bp_col_kept", col_out, held);
        applyStimulus(32'h5c220af2, 1'b0, lat, res);
        checkOutput("bp_next_col", res, 32'h9d58dc9f);
        checkOutput("bp_next_lat", 32'(lat), 32'(FWD_LAT));

        // Mode and data changes while busy must not disturb the in-flight column.
        tick();
        in_valid = 1'b1;
        col_in   = 32'hbca14d8e;
        dec      = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            dec    = ~dec;
            col_in = col_in ^ 32'hffffffff;
            tick();
        end
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        checkOutput("dec_toggle_col", col_out, 32'h455313db);

        // Reset during CALC with idx=2 discards the partial result.
        tick();
        tick();
        in_valid = 1'b1;
        col_in   = 32'h455313db;
        dec      = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        g_rst = 1'b1;
        tick();
        checkOutput("midrst_state", {29'h0, out_valid, busy, in_ready}, 32'h0);
        checkOutput("midrst_col_out", col_out, 32'h0);
        g_rst = 1'b0;
        #1;
        checkOutput("midrst_ready", {31'h0, in_ready}, 32'h1);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput($sformatf("midrst_no_out%0d", i), {31'h0, out_valid}, 32'h0);
        end
        applyStimulus(32'hbca14d8e, 1'b1, lat, res);
        checkOutput("midrst_after_col", res, 32'h455313db);

        // Reset together with a handshake: nothing is captured.
        tick();
        g_rst    = 1'b1;
        in_valid = 1'b1;
        col_in   = 32'hdeadbeef;
        dec      = 1'b0;
        tick();
        g_rst    = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("rst_hs_idle", {29'h0, out_valid, busy, in_ready}, 32'h1);
        tick();
        checkOutput("rst_hs_still_idle", {30'h0, busy, out_valid}, 32'h0);

        for (int i = 0; i < 40; i++) begin
            rc = $urandom;
            rd = 1'($urandom_range(0, 1));
            applyStimulus(rc, rd, lat, res);
            checkOutput($sformatf("rand%0d_col", i), res, ref_mix(rc, rd));
            checkOutput($sformatf("rand%0d_lat", i), 32'(lat), rd ? 32'(INV_LAT) : 32'(FWD_LAT));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
